lfsr_rr_server: RTL and testbench
=================================

# lfsr_rr_server

Shared pseudo-random word server. It owns one BITS-wide LFSR and hands out a freshly stepped word to one of N_REQ requesters at a time, using round-robin arbitration. Each grant advances the LFSR STEPS times before delivery, so consecutive consumers never receive correlated adjacent states. It sits between the LFSR datapath and the client blocks (game logic, test pattern sources) that previously each instantiated their own LFSR.

## Interface
- BITS, 5, LFSR width; values below 4 are forced to 4 (effective width B).
- N_REQ, 4, number of requesters (≥2).
- STEPS, BITS, LFSR shifts per delivered word (≥1).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- req  in  N_REQ  per-requester request level; held until its grant.
- seed_load  in  1  one-cycle strobe to load `seed` into the LFSR.
- seed  in  B  seed value.
- grant  out  N_REQ  one-hot, one-cycle pulse marking the receiver of rand_word.
- rand_word  out  B  delivered word; holds its value between deliveries.
- rand_valid  out  1  one-cycle pulse, coincident with grant.
- busy  out  1  high while not in IDLE.

## Operation
- LFSR step: next = {v[0]^v[2], v[B-1:1]}. If v == 0 at a step, the step loads all-ones instead.
- Reset (reset low, asynchronous): state IDLE, LFSR all-ones, ptr = N_REQ-1, cnt = 0, grant = 0, rand_valid = 0, rand_word = 0, busy = 0.
- FSM states: IDLE and SHIFT.
- IDLE:
  - seed_load high: LFSR <= seed, or all-ones if seed == 0. Stay in IDLE. seed_load takes priority over req in the same cycle.
  - Else any req bit set: win = first set index scanning (ptr+1+k) mod N_REQ for k = 0..N_REQ-1. Latch win, cnt <= STEPS-1, go to SHIFT. The LFSR does not step on this edge.
- SHIFT: every edge steps the LFSR.
  - cnt > 0: cnt <= cnt-1.
  - cnt == 0: register rand_word <= stepped value, grant <= onehot(win), rand_valid <= 1, ptr <= win, go to IDLE.
- grant and rand_valid default to 0 on every edge where they are not set.
- req changes during SHIFT are ignored. The latched winner still receives its word even if its req dropped.
- seed_load during SHIFT is ignored, not queued.
- Round-robin pointer wraps N_REQ-1 → 0. A lone requester is granted on every request.

## Timing
- Req sampled in IDLE at edge E0. Shifts occur at E1..E_STEPS. grant, rand_valid and rand_word update at E_STEPS and are valid for one cycle.
- Request-to-delivery latency is STEPS+1 edges. Peak throughput is one word per STEPS+1 cycles, because IDLE can accept a new request at E_STEPS+1.
- busy is combinational from state: high from E0+ through E_STEPS.
- Reset asserted mid-SHIFT clears all outputs immediately and abandons the word. No grant is issued for it.
- All outputs are registered except busy.

## Test plan
- BITS=5, STEPS=1, N_REQ=4; after reset, pulse req[0] five times, waiting for each grant → words 0x0F, 0x07, 0x03, 0x11, 0x18. Each grant is 4'b0001, asserted 2 edges after its request.
- BITS=5, STEPS=5; after reset, req=4'b0001 → single rand_valid at E5 with rand_word=0x18. busy is high for 5 cycles. rand_word holds 0x18 afterwards.
- STEPS=1; req=4'b1111 held continuously → grants 0001, 0010, 0100, 1000, 0001 on successive deliveries, one every 2 cycles. Then req=4'b1010 after a grant to 0010 → next grant is 1000, then 0010.
- seed_load with seed=0x00, then req[2], STEPS=1 → LFSR all-ones, word 0x0F. seed_load with seed=0x03 in the same IDLE cycle as req[1] → seed wins, req[1] is served on the following cycle with word 0x11. seed_load during SHIFT → no effect on the delivered word.
- STEPS=5; reset pulsed low at E3 of a SHIFT → grant, rand_valid and rand_word go to 0 asynchronously, no grant follows. The next req[0] yields 0x18, showing the LFSR returned to all-ones.
- Drop req[3] one cycle after it is latched → grant 4'b1000 is still issued with a valid word, and ptr advances to 3.

Source files
------------

// File: rtl/lfsr_rr_server.sv
`timescale 1ns/1ps
// lfsr_rr_server
// One shared BITS-wide LFSR that serves pseudo-random words to N_REQ
// requesters in round-robin order. A grant steps the LFSR STEPS times and then
// delivers the last stepped value, so back-to-back consumers never see
// adjacent LFSR states.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req         per-requester request level, held until its grant
//   seed_load   one-cycle strobe, loads seed into the LFSR (IDLE only)
//   seed        seed value (B bits)
//   grant       one-hot, one-cycle pulse naming the receiver of rand_word
//   rand_word   delivered word, holds between deliveries
//   rand_valid  one-cycle pulse coincident with grant
//   busy        high while not in IDLE (combinational from state)
//   dbg_state   current FSM state (0 = IDLE, 1 = SHIFT)
//   dbg_ptr     round-robin pointer (index of the last winner)
//
// Handshake: a requester raises its req bit and holds it until it sees its
// grant bit; the word on rand_word is valid in the cycle rand_valid is high.
// Requests arriving while busy wait; seed_load while busy is dropped.
module lfsr_rr_server #(
  parameter int BITS  = 5,
  parameter int N_REQ = 4,
  parameter int STEPS = BITS,
  localparam int B  = (BITS < 4) ? 4 : BITS,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [B-1:0]     seed,
  output logic [N_REQ-1:0] grant,
  output logic [B-1:0]     rand_word,
  output logic             rand_valid,
  output logic             busy,
  output logic             dbg_state,
  output logic [PW-1:0]    dbg_ptr
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [B-1:0]       r_lfsr;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_win;
  logic [CW-1:0]      r_cnt;
  logic [N_REQ-1:0]   r_grant;
  logic [B-1:0]       r_word;
  logic               r_valid;

  logic               w_any;
  logic [PW-1:0]      w_win;
  logic               w_start;
  logic               w_last;
  logic [B-1:0]       w_step;

  // One LFSR step. The all-zero state is a lock-up state, so it is replaced
  // by all-ones instead of being shifted.
  function automatic logic [B-1:0] f_step(input logic [B-1:0] v);
    if (v == '0) begin
      return '1;
    end
    return {v[0] ^ v[2], v[B-1:1]};
  endfunction

  assign w_step = f_step(r_lfsr);

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + 1 + k) % N_REQ;
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = PW'(idx);
      end
    end
  end

  // seed_load wins over a request arriving in the same IDLE cycle.
  assign w_start = (r_state == S_IDLE) && !seed_load && w_any;
  assign w_last  = (r_state == S_SHIFT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr  <= '1;
      r_ptr   <= PW'(N_REQ - 1);
      r_win   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_grant <= '0;
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (seed_load) begin
          r_lfsr <= (seed == '0) ? '1 : seed;
        end else if (w_any) begin
          // The LFSR does not move on the accept edge; shifting starts next.
          r_win <= w_win;
          r_cnt <= CW'(STEPS - 1);
        end
      end else begin
        r_lfsr <= w_step;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_word  <= w_step;
          r_grant <= N_REQ'(1) << r_win;
          r_valid <= 1'b1;
          r_ptr   <= r_win;
        end
      end
    end
  end

  assign grant      = r_grant;
  assign rand_word  = r_word;
  assign rand_valid = r_valid;
  assign busy       = (r_state == S_SHIFT);
  assign dbg_state  = r_state;
  assign dbg_ptr    = r_ptr;

endmodule

// File: tb/tb_lfsr_rr_server.sv
`timescale 1ns/1ps
module tb_lfsr_rr_server;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [3:0] req1 = '0, req5 = '0;
  logic       seed_load1 = 1'b0, seed_load5 = 1'b0;
  logic [4:0] seed1 = '0, seed5 = '0;
  logic [3:0] grant1, grant5;
  logic [4:0] word1, word5;
  logic       valid1, valid5, busy1, busy5, st1, st5;
  logic [1:0] ptr1, ptr5;

  lfsr_rr_server #(.BITS(5), .N_REQ(4), .STEPS(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .seed_load(seed_load1), .seed(seed1),
    .grant(grant1), .rand_word(word1), .rand_valid(valid1), .busy(busy1),
    .dbg_state(st1), .dbg_ptr(ptr1)
  );

  lfsr_rr_server #(.BITS(5), .N_REQ(4), .STEPS(5)) dut5 (
    .clk(clk), .reset(reset), .req(req5), .seed_load(seed_load5), .seed(seed5),
    .grant(grant5), .rand_word(word5), .rand_valid(valid5), .busy(busy5),
    .dbg_state(st5), .dbg_ptr(ptr5)
  );

  // ---------------- scoreboard ----------------
  // entry = {delivery cycle[15:0], grant[3:0], word[4:0]}
  logic [24:0] exp_q1[$];
  logic [24:0] exp_q5[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [24:0] mk(input int c, input logic [3:0] g, input logic [4:0] w);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, g, w};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (valid1 || (grant1 != '0)) begin
      logic [24:0] e;
      check("dut1_valid_with_grant", {31'd0, valid1}, {31'd0, |grant1});
      if (exp_q1.size() == 0) begin
        check("dut1_unexpected_grant", {28'd0, grant1}, 32'd0);
      end else begin
        e = exp_q1.pop_front();
        check("dut1_cycle", {16'd0, cyc[15:0]}, {16'd0, e[24:9]});
        check("dut1_grant", {28'd0, grant1}, {28'd0, e[8:5]});
        check("dut1_word",  {27'd0, word1},  {27'd0, e[4:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (valid5 || (grant5 != '0)) begin
      logic [24:0] e;
      check("dut5_valid_with_grant", {31'd0, valid5}, {31'd0, |grant5});
      if (exp_q5.size() == 0) begin
        check("dut5_unexpected_grant", {28'd0, grant5}, 32'd0);
      end else begin
        e = exp_q5.pop_front();
        check("dut5_cycle", {16'd0, cyc[15:0]}, {16'd0, e[24:9]});
        check("dut5_grant", {28'd0, grant5}, {28'd0, e[8:5]});
        check("dut5_word",  {27'd0, word5},  {27'd0, e[4:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input bit s5, input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (s5 ? grant5[idx] : grant1[idx]) seen = 1'b1;
    end
    if (!seen) check("grant_timeout", 32'd0, 32'd1);
    if (s5) req5[idx] = 1'b0;
    else    req1[idx] = 1'b0;
  endtask

  // Issue one request from idle and expect word w after STEPS+1 edges.
  task automatic serve(input bit s5, input int idx, input logic [4:0] w);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(posedge clk); #1;
    if (s5) begin
      req5[idx] = 1'b1;
      exp_q5.push_back(mk(cyc + 6, oh, w));
    end else begin
      req1[idx] = 1'b1;
      exp_q1.push_back(mk(cyc + 2, oh, w));
    end
    wait_grant(s5, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_state", {31'd0, st1}, 32'd0);
    check("rst_busy",  {31'd0, busy1}, 32'd0);
    check("rst_ptr",   {30'd0, ptr1}, 32'd3);
    check("rst_word",  {27'd0, word1}, 32'd0);
    check("rst_grant", {28'd0, grant1}, 32'd0);
    check("rst_valid", {31'd0, valid1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // lone requester, STEPS=1
    serve(0, 0, 5'h0F);
    serve(0, 0, 5'h07);
    serve(0, 0, 5'h03);
    serve(0, 0, 5'h11);
    serve(0, 0, 5'h18);
    check("lone_ptr", {30'd0, ptr1}, 32'd0);

    // all requesters held, STEPS=1
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    req1 = 4'b1111;
    exp_q1.push_back(mk(c + 2,  4'b0001, 5'h0F));
    exp_q1.push_back(mk(c + 4,  4'b0010, 5'h07));
    exp_q1.push_back(mk(c + 6,  4'b0100, 5'h03));
    exp_q1.push_back(mk(c + 8,  4'b1000, 5'h11));
    exp_q1.push_back(mk(c + 10, 4'b0001, 5'h18));
    exp_q1.push_back(mk(c + 12, 4'b0010, 5'h0C));
    exp_q1.push_back(mk(c + 14, 4'b1000, 5'h16));
    exp_q1.push_back(mk(c + 16, 4'b0010, 5'h1B));
    wait_cyc(c + 12);
    req1 = 4'b1010;
    wait_cyc(c + 16);
    req1 = 4'b0000;
    repeat (3) @(negedge clk);

    // seed handling, STEPS=1
    do_reset();
    @(posedge clk); #1;
    seed_load1 = 1'b1; seed1 = 5'h00;
    @(posedge clk); #1;
    seed_load1 = 1'b0;
    req1[2] = 1'b1;
    exp_q1.push_back(mk(cyc + 2, 4'b0100, 5'h0F));
    wait_grant(0, 2);
    @(posedge clk); #1;
    seed_load1 = 1'b1; seed1 = 5'h03; req1[1] = 1'b1;
    exp_q1.push_back(mk(cyc + 3, 4'b0010, 5'h11));
    @(posedge clk); #1;
    seed_load1 = 1'b0;
    check("seed_wins_idle", {31'd0, busy1}, 32'd0);
    wait_grant(0, 1);
    @(posedge clk); #1;
    req1[0] = 1'b1;
    exp_q1.push_back(mk(cyc + 2, 4'b0001, 5'h18));
    @(posedge clk); #1;
    check("seed_in_shift_busy", {31'd0, busy1}, 32'd1);
    seed_load1 = 1'b1; seed1 = 5'h0A;
    @(posedge clk); #1;
    seed_load1 = 1'b0;
    wait_grant(0, 0);
    repeat (2) @(negedge clk);

    // STEPS=5 single delivery and busy window
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    req5[0] = 1'b1;
    exp_q5.push_back(mk(c + 6, 4'b0001, 5'h18));
    @(negedge clk);
    check("busy_before", {31'd0, busy5}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("busy_shift", {31'd0, busy5}, 32'd1);
    end
    @(negedge clk);
    check("busy_after", {31'd0, busy5}, 32'd0);
    req5[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("word_hold", {27'd0, word5}, 32'h18);
    check("valid_low_hold", {31'd0, valid5}, 32'd0);

    // reset in the middle of SHIFT
    @(posedge clk); #1;
    req5[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_grant", {28'd0, grant5}, 32'd0);
    check("mid_rst_valid", {31'd0, valid5}, 32'd0);
    check("mid_rst_word",  {27'd0, word5}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy5}, 32'd0);
    req5[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    serve(1, 0, 5'h18);

    // req[3] dropped after being latched
    @(posedge clk); #1;
    c = cyc;
    req5[3] = 1'b1;
    exp_q5.push_back(mk(c + 6, 4'b1000, 5'h0E));
    @(posedge clk); #1;
    req5[3] = 1'b0;
    wait_cyc(c + 6);
    @(negedge clk);
    check("drop_ptr", {30'd0, ptr5}, 32'd3);
    check("drop_idle", {31'd0, st5}, 32'd0);

    repeat (5) @(negedge clk);
    check("q1_empty", exp_q1.size(), 32'd0);
    check("q5_empty", exp_q5.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
